instruction_queue: RTL

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

---
 rtl/instruction_queue_if.sv | 31 +++
 rtl/instruction_queue.sv | 127 ++++++++++++
 2 files changed

// File: rtl/instruction_queue_if.sv
// Fetch/execute handshake bundle for instruction_queue.
// The fetcher side uses the master modport, and the queue uses the slave modport.
interface instruction_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 10
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]     in_instruction;
    logic [PC_W-1:0] in_pc;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     out_instruction;
    logic [PC_W-1:0] out_pc;
    logic            out_valid;
    logic            out_ready;
    logic            flush;
    logic [CW-1:0]   count;

    // Fetcher/executor environment side
    modport master (
        output in_instruction, in_pc, in_valid, out_ready, flush,
        input  in_ready, out_instruction, out_pc, out_valid, count
    );

    // Queue side
    modport slave (
        input  in_instruction, in_pc, in_valid, out_ready, flush,
        output in_ready, out_instruction, out_pc, out_valid, count
    );
endinterface

// File: rtl/instruction_queue.sv
// instruction_queue: a circular-buffer FIFO that sits between the fetcher and the executor.
// Each queued word carries the PC it was fetched from. A word pushed into an empty queue
// appears at the head one cycle later. There is no same-cycle bypass.
// Optional feature: define IQ_JMP_STALL_EN to block further fetches after a JMP
// (opcode 8'h01) is queued. A flush or reset clears that block.
module instruction_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    instruction_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [7:0]    OPC_JMP    = 8'h01;

    // Payload storage. This memory has no reset, so it can map onto RAM.
    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];

    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d;

    logic in_ready_w;
    logic out_valid_w;
    logic push_w;
    logic pop_w;

`ifdef IQ_JMP_STALL_EN
    logic stall_q;

    // The stall flag is set when a JMP is actually enqueued and is cleared on redirect.
    // A JMP offered during a flush is never pushed, so it cannot set the flag.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            stall_q <= 1'b0;
        end else if (push_w && (bus.in_instruction[31:24] == OPC_JMP)) begin
            stall_q <= 1'b1;
        end
    end

    assign in_ready_w = (count_q < FULL_COUNT) && !stall_q;
`else
    assign in_ready_w = (count_q < FULL_COUNT);
`endif

    // A full queue refuses a push even if a pop happens in the same cycle.
    // This keeps in_ready a function of registered state only.
    assign out_valid_w = (count_q != '0);
    assign push_w      = bus.in_valid && in_ready_w && !bus.flush;
    assign pop_w       = out_valid_w && bus.out_ready && !bus.flush;

    // Next-state logic for the pointers, the occupancy count and the registered head view
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_w) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop_w) begin
                head_d = head_q + 1'b1;
            end
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // Preload the head word for the next cycle. When the queue empties,
            // the last value is kept. If the word being written becomes the new head,
            // it is forwarded, because the memory write lands on the same edge.
            if (count_d != '0) begin
                if (push_w && (tail_q == head_d)) begin
                    out_instr_d = bus.in_instruction;
                    out_pc_d    = bus.in_pc;
                end else begin
                    out_instr_d = instr_mem[head_d];
                    out_pc_d    = pc_mem[head_d];
                end
            end
        end
    end

    // Control and output registers. Reset overrides flush, push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    // Write the accepted word and its PC at the tail slot
    always_ff @(posedge clk) begin
        if (!rst && push_w) begin
            instr_mem[tail_q] <= bus.in_instruction;
            pc_mem[tail_q]    <= bus.in_pc;
        end
    end

    assign bus.in_ready        = in_ready_w;
    assign bus.out_valid       = out_valid_w;
    assign bus.out_instruction = out_instr_q;
    assign bus.out_pc          = out_pc_q;
    assign bus.count           = count_q;

endmodule
